// File: rtl/cpu_pkg.sv
// Shared widths, reset constants and the fetch-buffer entry type for the MIPS core.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP          = 32'h0000_0000;

  // One fetched instruction together with its fall-through address.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer: strict FIFO order, synchronous flush, registered head.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       wdata,
  output fetch_entry_t       rdata,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t mem [DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '{instr: NOP, pc_plus4: '0};
      end
    end else if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; a flush discards everything, including any entry popped this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and a two-entry buffer toward decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next_c;
  logic [ADDR_W-1:0] pc_plus4_c;
  logic [CNT_W-1:0]  count;
  logic              push_c;
  logic              pop_c;
  fetch_entry_t      wdata_c;
  fetch_entry_t      head;

  assign pc_plus4_c = pc + ADDR_W'(4);
  assign pop_c      = id_valid & id_ready;
  assign push_c     = ((count < CNT_W'(DEPTH)) | pop_c) & ~redirect_valid;
  assign wdata_c    = '{instr: imem_data, pc_plus4: pc_plus4_c};

  // Next-PC: redirect wins, otherwise advance only when the fetched word was accepted.
  always_comb begin
    pc_next_c = pc;
    if (redirect_valid) begin
      pc_next_c = redirect_pc & ~ADDR_W'(3);
    end else if (push_c) begin
      pc_next_c = pc_plus4_c;
    end
  end

  // Program counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next_c;
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (wdata_c),
    .rdata (head),
    .count (count)
  );

  assign imem_addr   = pc;
  assign id_valid    = (count != '0);
  assign id_instr    = head.instr;
  assign id_pc_plus4 = head.pc_plus4;

endmodule
